// File: rtl/dsm_sample_sequencer.sv
// Delta-sigma sample sequencer: holds each streamed sample on vin for osr clocks, sequences the
// modulator reset around start/stop, and counts pwm ones per sample period.
module dsm_sample_sequencer #(
  parameter int                DATA_W    = 20,
  parameter int                OSR_W     = 8,
  parameter int                FLUSH_CYC = 4,
  parameter logic [DATA_W-1:0] MUTE_CODE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_i,
  input  logic [OSR_W-1:0]  osr_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] vin_o,
  output logic              dsm_reset_o,
  input  logic              pwm_i,
  output logic [OSR_W:0]    ones_count_o,
  output logic              period_done_o,
  output logic              underrun_o,
  output logic              busy_o
);

  // state | meaning
  // IDLE  | modulator held in reset, vin muted, waiting for enable
  // FLUSH | modulator reset held for FLUSH_CYC cycles after a start
  // PRIME | modulator released, vin muted, waiting for the first sample
  // RUN   | each sample held osr_q cycles; pwm ones counted per period
  // STOP  | single wind-down cycle after the last period, then IDLE
  typedef enum logic [2:0] {ST_IDLE, ST_FLUSH, ST_PRIME, ST_RUN, ST_STOP} state_t;

  localparam int                 FLUSH_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYC - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [OSR_W-1:0]   OSR_ONE    = OSR_W'(1);

  state_t             state_q, state_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic [OSR_W-1:0]   osr_q, osr_d;
  logic [OSR_W-1:0]   hold_q, hold_d;
  logic [OSR_W:0]     acc_q, acc_d, acc_inc;
  logic [OSR_W:0]     ones_q, ones_d;
  logic [DATA_W-1:0]  vin_q, vin_d;
  logic               dsm_reset_q, dsm_reset_d;
  logic               done_q, done_d;
  logic               underrun_q, underrun_d;
  logic               term, xfer;

  assign term    = (hold_q == osr_q - OSR_ONE);
  assign acc_inc = acc_q + {{OSR_W{1'b0}}, pwm_i};

  // Ready is a function of state and enable only; gated by reset so a reset cycle never transfers.
  assign s_ready_o = !reset && ((state_q == ST_PRIME) || (state_q == ST_RUN && term && enable_i));
  assign xfer      = s_valid_i && s_ready_o;

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    osr_d      = osr_q;
    hold_d     = hold_q;
    acc_d      = acc_q;
    vin_d      = vin_q;
    ones_d     = ones_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    case (state_q)
      ST_IDLE: begin
        vin_d = MUTE_CODE;
        if (enable_i) begin
          state_d    = ST_FLUSH;
          flush_d    = FLUSH_LOAD;
          osr_d      = (osr_i == '0) ? OSR_ONE : osr_i;
          underrun_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (!enable_i)          state_d = ST_IDLE;
        else if (flush_q == '0) state_d = ST_PRIME;
        else                    flush_d = flush_q - FLUSH_ONE;
      end
      ST_PRIME: begin
        vin_d = MUTE_CODE;
        if (xfer) begin
          vin_d   = s_data_i;
          hold_d  = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (term) begin
          ones_d = acc_inc;
          done_d = 1'b1;
          acc_d  = '0;
          hold_d = '0;
          if (!enable_i) begin
            vin_d   = MUTE_CODE;
            state_d = ST_STOP;
          end else if (xfer) begin
            vin_d = s_data_i;
          end else begin
            vin_d      = MUTE_CODE;
            underrun_d = 1'b1;
          end
        end else begin
          acc_d  = acc_inc;
          hold_d = hold_q + OSR_ONE;
        end
      end
      ST_STOP: begin
        vin_d   = MUTE_CODE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    dsm_reset_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_q     <= '0;
      osr_q       <= OSR_ONE;
      hold_q      <= '0;
      acc_q       <= '0;
      vin_q       <= MUTE_CODE;
      dsm_reset_q <= 1'b1;
      ones_q      <= '0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      osr_q       <= osr_d;
      hold_q      <= hold_d;
      acc_q       <= acc_d;
      vin_q       <= vin_d;
      dsm_reset_q <= dsm_reset_d;
      ones_q      <= ones_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign vin_o         = vin_q;
  assign dsm_reset_o   = dsm_reset_q;
  assign ones_count_o  = ones_q;
  assign period_done_o = done_q;
  assign underrun_o    = underrun_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule
